mux_scan_sefunmi: RTL and testbench
===================================

Name: mux_scan_sefunmi

Overview:
Parametrised, registered N-to-1 multiplexer with enable and two selection modes.
- Manual mode: the channel comes from the select input.
- Auto-scan mode: an internal counter steps through all channels, dwelling a programmable number of cycles on each.
- Next generation of the team's 8:1 mux (and its delayed variant): generalised in channel count and data width, with clocked output and scan sequencing.
- Used as the front-end channel sequencer for multi-input sampling paths.

Parameters:
- N, 8: number of input channels, 2..64.
- W, 1: data width of each channel in bits.
- DWELL, 1: cycles spent on each channel in auto-scan mode, 1..255.
- SEL_W, clog2(N): select width, derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  block enable; low forces outputs inactive.
- mode  input  1  0 = manual, 1 = auto-scan.
- select  input  SEL_W  manual channel index.
- mux_in  input  N*W  packed channels; channel k = mux_in[k*W +: W].
- mux_out  output  W  registered selected data.
- out_sel  output  SEL_W  registered index of the channel shown on mux_out.
- out_valid  output  1  mux_out holds a valid channel.
- scan_wrap  output  1  one-cycle pulse when the scan index wraps N-1 -> 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Reset values: mux_out = 0, out_sel = 0, out_valid = 0, scan_wrap = 0. Internal scan_idx = 0, dwell_cnt = 0.
- All outputs are registered. Latency is 1 cycle from input change to output.
- enable = 0:
  - next cycle mux_out = 0, out_valid = 0, scan_wrap = 0;
  - out_sel holds;
  - scan_idx and dwell_cnt hold (scan resumes where it stopped).
- Manual mode (mode = 0, enable = 1):
  - mux_out <= channel[select], out_sel <= select, out_valid <= 1.
  - If select >= N: mux_out <= 0, out_valid <= 0, out_sel <= select.
- Auto-scan mode (mode = 1, enable = 1):
  - mux_out <= channel[scan_idx], out_sel <= scan_idx, out_valid <= 1.
  - dwell_cnt increments each cycle. When dwell_cnt == DWELL-1, dwell_cnt <= 0 and scan_idx advances.
  - If scan_idx == N-1 at advance, scan_idx <= 0 and scan_wrap pulses in the cycle out_sel first shows 0.
  - DWELL = 1 advances every cycle.
- Mode change 0 -> 1: scan_idx and dwell_cnt clear to 0 in that cycle, so the first scanned channel is 0.
- Mode change 1 -> 0: scan state is discarded.
- Reset has priority over enable and mode. Reset mid-scan returns to the reset state on the next edge; the scan restarts at 0.
- Non-power-of-2 N: scan_idx never reaches values >= N.

Optional Feature:
Macro: MUX_SCAN_CH_MASK_EN.
- Defined:
  - adds input ch_mask [N-1:0], 1 = channel active;
  - auto-scan skips inactive channels (next active index, wrapping; scan_wrap pulses whenever the index decreases);
  - manual select of an inactive channel gives mux_out = 0, out_valid = 0;
  - all channels masked: out_valid = 0, scan_idx holds;
  - mask changes take effect at the next advance.
- Undefined: port absent; all channels active; behaviour as above.

Decomposition:
- Shared package/header mux_defs_sefunmi:
  - clog2 function;
  - MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1;
  - MAX_N = 64, MAX_DWELL = 255.
- One sub-module: scan_counter_sefunmi. It holds scan_idx, dwell_cnt, wrap pulse and mask skip logic. Inputs: clk, reset, run, restart, ch_mask. Outputs: idx, wrap.
- The top level holds the select mux and output registers.

Test Plan:
1. N=8, W=1, mux_in=8'b10101010, mode=0, enable=1, select stepped 0..7 every 2 cycles -> mux_out = 0,1,0,1,0,1,0,1, each 1 cycle after select; out_valid = 1.
2. Same setup, enable dropped to 0 -> next cycle mux_out = 0, out_valid = 0. Re-enable with select=3 -> mux_out = 1 one cycle later.
3. mode=1, DWELL=2 -> out_sel sequence 0,0,1,1,...,7,7,0,0. scan_wrap = 1 only on the first cycle out_sel returns to 0. mux_out tracks 8'b10101010 bits.
4. Reset asserted for 1 cycle while out_sel=5 in scan -> next cycle all outputs 0. After release, scan restarts at out_sel=0 with full dwell.
5. N=6, mode=0, select=7 -> out_valid = 0, mux_out = 0, out_sel = 7. Then select=5 -> out_valid = 1, mux_out = channel 5.
6. With MUX_SCAN_CH_MASK_EN, N=8, ch_mask=8'b11110101, DWELL=1 -> out_sel 0,2,4,5,6,7,0 with wrap on 0. ch_mask=0 -> out_valid = 0, out_sel holds.

Source files
------------

// File: rtl/mux_scan_sefunmi_pkg.sv
// Shared definitions for the scanning channel multiplexer: mode encoding, limits
// and a constant-foldable clog2 used to size select and counter fields.
package mux_scan_sefunmi_pkg;

  localparam int MAX_N     = 64;
  localparam int MAX_DWELL = 255;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
      else                        result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_scan_sefunmi_if.sv
// Channel bus of the scanning multiplexer. The ch_mask signal exists only when
// MUX_SCAN_CH_MASK_EN is defined.
interface mux_scan_sefunmi_if #(
  parameter int N = 8,
  parameter int W = 1
);
  import mux_scan_sefunmi_pkg::*;

  localparam int SEL_W = clog2(N);

  logic             enable;
  logic             mode;
  logic [SEL_W-1:0] select;
  logic [N*W-1:0]   mux_in;
`ifdef MUX_SCAN_CH_MASK_EN
  logic [N-1:0]     ch_mask;
`endif
  logic [W-1:0]     mux_out;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             scan_wrap;

  modport master (
    output enable, mode, select, mux_in,
`ifdef MUX_SCAN_CH_MASK_EN
    output ch_mask,
`endif
    input  mux_out, out_sel, out_valid, scan_wrap
  );

  modport slave (
    input  enable, mode, select, mux_in,
`ifdef MUX_SCAN_CH_MASK_EN
    input  ch_mask,
`endif
    output mux_out, out_sel, out_valid, scan_wrap
  );

endinterface

// File: rtl/scan_counter_sefunmi.sv
// Auto-scan sequencer: dwells DWELL cycles per channel, then steps to the next
// active channel (wrapping) and raises a one-cycle wrap flag with the new index.
module scan_counter_sefunmi
  import mux_scan_sefunmi_pkg::*;
#(
  parameter int N     = 8,
  parameter int DWELL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                restart,
  input  logic [N-1:0]        ch_mask,
  output logic [clog2(N)-1:0] idx,
  output logic                wrap
);

  localparam int SEL_W = clog2(N);
  localparam int CNT_W = clog2(MAX_DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] idx_r;
  logic [SEL_W-1:0] next_idx_s;
  logic [CNT_W-1:0] dwell_cnt_r;
  logic             wrap_r;
  logic             found_s;
  logic             wrap_s;
  int               cand_s;

  // Search forward from the current index for the next active channel.
  always_comb begin
    next_idx_s = idx_r;
    found_s    = 1'b0;
    cand_s     = 0;
    for (int k = 1; k <= N; k++) begin
      cand_s = int'(idx_r) + k;
      if (cand_s >= N) cand_s = cand_s - N;
      else             cand_s = cand_s;
      if (!found_s && ch_mask[cand_s[SEL_W-1:0]]) begin
        found_s    = 1'b1;
        next_idx_s = cand_s[SEL_W-1:0];
      end else begin
        found_s    = found_s;
      end
    end
    wrap_s = found_s && (next_idx_s < idx_r);
  end

  // Index, dwell counter and wrap flag; manual mode keeps the scan parked at 0.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      idx_r       <= {SEL_W{1'b0}};
      dwell_cnt_r <= {CNT_W{1'b0}};
      wrap_r      <= 1'b0;
    end else if (run) begin
      if (dwell_cnt_r == DWELL_LAST) begin
        dwell_cnt_r <= {CNT_W{1'b0}};
        idx_r       <= next_idx_s;
        wrap_r      <= wrap_s;
      end else begin
        dwell_cnt_r <= dwell_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        wrap_r      <= 1'b0;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: rtl/mux_scan_sefunmi.sv
// Registered N-to-1 channel multiplexer with manual select and auto-scan modes.
// Optional per-channel mask enabled by defining MUX_SCAN_CH_MASK_EN.
module mux_scan_sefunmi
  import mux_scan_sefunmi_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 1
) (
  input  logic                clk,
  input  logic                reset,
  mux_scan_sefunmi_if.slave   bus
);

  localparam int SEL_W = clog2(N);
  localparam int SLOTS = 1 << SEL_W;

  mode_e            mode_s;
  logic [N-1:0]     mask_s;
  logic [SLOTS-1:0] active_s;
  logic [W-1:0]     chan_s [SLOTS];
  logic             run_s;
  logic             restart_s;
  logic [SEL_W-1:0] scan_idx_s;
  logic             scan_wrap_s;
  logic [SEL_W-1:0] pick_s;
  logic [W-1:0]     nxt_out_s;
  logic [SEL_W-1:0] nxt_sel_s;
  logic             nxt_valid_s;
  logic             nxt_wrap_s;
  logic [W-1:0]     mux_out_r;
  logic [SEL_W-1:0] out_sel_r;
  logic             out_valid_r;
  logic             scan_wrap_r;

`ifdef MUX_SCAN_CH_MASK_EN
  assign mask_s = bus.ch_mask;
`else
  assign mask_s = {N{1'b1}};
`endif

  // Select codes beyond N map to an inactive, zero-valued slot.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < N) begin : g_real
      assign active_s[i] = mask_s[i];
      assign chan_s[i]   = bus.mux_in[i*W +: W];
    end else begin : g_pad
      assign active_s[i] = 1'b0;
      assign chan_s[i]   = {W{1'b0}};
    end
  end

  assign mode_s    = mode_e'(bus.mode);
  assign run_s     = bus.enable & (mode_s == MODE_SCAN);
  assign restart_s = (mode_s == MODE_MANUAL);

  scan_counter_sefunmi #(
    .N     (N),
    .DWELL (DWELL)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .run     (run_s),
    .restart (restart_s),
    .ch_mask (mask_s),
    .idx     (scan_idx_s),
    .wrap    (scan_wrap_s)
  );

  // Next output values: pick a channel by mode, or go inactive when disabled.
  always_comb begin
    pick_s      = bus.select;
    nxt_out_s   = {W{1'b0}};
    nxt_sel_s   = out_sel_r;
    nxt_valid_s = 1'b0;
    nxt_wrap_s  = 1'b0;
    if (bus.enable) begin
      case (mode_s)
        MODE_MANUAL: begin
          pick_s     = bus.select;
          nxt_wrap_s = 1'b0;
        end
        MODE_SCAN: begin
          pick_s     = scan_idx_s;
          nxt_wrap_s = scan_wrap_s;
        end
        default: begin
          pick_s     = bus.select;
          nxt_wrap_s = 1'b0;
        end
      endcase
      nxt_sel_s   = pick_s;
      nxt_valid_s = active_s[pick_s];
      nxt_out_s   = active_s[pick_s] ? chan_s[pick_s] : {W{1'b0}};
    end else begin
      nxt_sel_s = out_sel_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_out_r   <= {W{1'b0}};
      out_sel_r   <= {SEL_W{1'b0}};
      out_valid_r <= 1'b0;
      scan_wrap_r <= 1'b0;
    end else begin
      mux_out_r   <= nxt_out_s;
      out_sel_r   <= nxt_sel_s;
      out_valid_r <= nxt_valid_s;
      scan_wrap_r <= nxt_wrap_s;
    end
  end

  assign bus.mux_out   = mux_out_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.out_valid = out_valid_r;
  assign bus.scan_wrap = scan_wrap_r;

endmodule

// File: tb/tb_mux_scan_sefunmi.sv
// Directed bench for mux_scan_sefunmi: an N=8/W=1/DWELL=2 instance and an
// N=6/W=4/DWELL=1 instance, checked through an expectation queue.
module tb_mux_scan_sefunmi;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux_scan_sefunmi_if #(.N(8), .W(1)) bus8 ();
  mux_scan_sefunmi_if #(.N(6), .W(4)) bus6 ();

  mux_scan_sefunmi #(.N(8), .W(1), .DWELL(2)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  mux_scan_sefunmi #(.N(6), .W(4), .DWELL(1)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6)
  );

  typedef struct packed {
    logic       which;
    logic [3:0] out;
    logic [2:0] sel;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic step(input logic which, input logic rst, input logic en, input logic md,
                      input logic [2:0] sel, input logic [3:0] eo, input logic [2:0] es,
                      input logic ev, input logic ew, input string tag);
    exp_t e;
    exp_t got;
    reset = rst;
    if (which == 1'b0) begin
      bus8.enable = en;
      bus8.mode   = md;
      bus8.select = sel;
    end else begin
      bus6.enable = en;
      bus6.mode   = md;
      bus6.select = sel;
    end
    q.push_back('{which, eo, es, ev, ew});
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.which == 1'b0)
      got = '{1'b0, {3'b000, bus8.mux_out}, bus8.out_sel, bus8.out_valid, bus8.scan_wrap};
    else
      got = '{1'b1, bus6.mux_out, bus6.out_sel, bus6.out_valid, bus6.scan_wrap};
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s: got out=%h sel=%0d valid=%b wrap=%b, want out=%h sel=%0d valid=%b wrap=%b",
             tag, got.out, got.sel, got.valid, got.wrap, e.out, e.sel, e.valid, e.wrap);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus8.enable = 1'b0;
    bus8.mode   = 1'b0;
    bus8.select = 3'd0;
    bus8.mux_in = 8'b1010_1010;
    bus6.enable = 1'b0;
    bus6.mode   = 1'b0;
    bus6.select = 3'd0;
    for (int k = 0; k < 6; k++) bus6.mux_in[k*4 +: 4] = 4'(10 + k);
`ifdef MUX_SCAN_CH_MASK_EN
    bus8.ch_mask = 8'hFF;
    bus6.ch_mask = 6'b111111;
`endif

    // reset state of both instances
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, "reset8");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, "reset6");

    // manual select stepping, channel k = bit k of 10101010
    for (int s = 0; s < 8; s++)
      repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 3'(s), 4'(s % 2), 3'(s), 1'b1, 1'b0, "manual8");

    // disable holds out_sel, clears data and valid; re-enable on channel 3
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 4'h0, 3'd7, 1'b0, 1'b0, "disable");
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'h1, 3'd3, 1'b1, 1'b0, "reenable");

    // auto-scan with dwell 2, wrap on the first return to 0, stop while showing 5
    for (int j = 0; j < 27; j++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'((j / 2) % 2), 3'((j / 2) % 8), 1'b1, 1'(j == 16), "scan8");

    // reset mid-scan, then the scan restarts at 0 with full dwell
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, "reset_mid_scan");
    for (int j = 0; j < 4; j++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'((j / 2) % 2), 3'(j / 2), 1'b1, 1'b0, "rescan8");

    // back to manual discards scan state; returning to scan starts at 0
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 4'h0, 3'd2, 1'b1, 1'b0, "manual_again");
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'((k / 2) % 2), 3'(k / 2), 1'b1, 1'b0, "scan_restart");

    // disable mid-dwell freezes the scan, which resumes where it stopped
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 3'd1, 1'b0, 1'b0, "scan_hold");
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'h1, 3'd1, 1'b1, 1'b0, "scan_resume");
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'h0, 3'd2, 1'b1, 1'b0, "scan_resume2");

    // N=6: select codes 6 and 7 are out of range
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 4'h0, 3'd7, 1'b0, 1'b0, "sel7_range");
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 4'h0, 3'd6, 1'b0, 1'b0, "sel6_range");
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 4'hF, 3'd5, 1'b1, 1'b0, "sel5");
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'hA, 3'd0, 1'b1, 1'b0, "sel0");

    // N=6 scan with dwell 1 never shows index 6 or 7
    for (int j = 0; j < 8; j++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 4'(10 + j % 6), 3'(j % 6), 1'b1, 1'(j == 6), "scan6");

`ifdef MUX_SCAN_CH_MASK_EN
    begin
      int ms [6];
      ms = '{0, 2, 4, 5, 0, 2};
      bus6.ch_mask = 6'b110101;
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'hA, 3'd0, 1'b1, 1'b0, "mask_pre");
      for (int i = 0; i < 6; i++)
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 4'(10 + ms[i]), 3'(ms[i]), 1'b1, 1'(i == 4), "mask_scan");
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 4'h0, 3'd1, 1'b0, 1'b0, "mask_manual_off");
      bus6.ch_mask = 6'b000000;
      repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 4'h0, 3'd0, 1'b0, 1'b0, "mask_all_off");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
